// File: rtl/l1c_pkg.sv
// Shared types and byte-lane helpers for the L1 data cache.
package l1c_pkg;

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, WRBACK} l1c_state_e;

    localparam logic [2:0] CT_B  = 3'd0;
    localparam logic [2:0] CT_H  = 3'd1;
    localparam logic [2:0] CT_W  = 3'd2;
    localparam logic [2:0] CT_BU = 3'd4;
    localparam logic [2:0] CT_HU = 3'd5;

    function automatic logic [3:0] be_from_type(input logic [2:0] ctype, input logic [1:0] off);
        case (ctype)
            CT_B, CT_BU: be_from_type = 4'b0001 << off;
            CT_H, CT_HU: be_from_type = off[1] ? 4'b1100 : 4'b0011;
            default:     be_from_type = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_align(input logic [31:0] data, input logic [2:0] ctype,
                                                input logic [1:0] off);
        case (ctype)
            CT_B, CT_BU: store_align = {24'b0, data[7:0]} << {off, 3'b000};
            CT_H, CT_HU: store_align = {16'b0, data[15:0]} << {off[1], 4'b0000};
            default:     store_align = data;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] ctype,
                                                input logic [1:0] off);
        logic [31:0] bsh;
        logic [31:0] hsh;
        bsh = word >> {off, 3'b000};
        hsh = word >> {off[1], 4'b0000};
        case (ctype)
            CT_B:    load_extend = {{24{bsh[7]}}, bsh[7:0]};
            CT_BU:   load_extend = {24'b0, bsh[7:0]};
            CT_H:    load_extend = {{16{hsh[15]}}, hsh[15:0]};
            CT_HU:   load_extend = {16'b0, hsh[15:0]};
            default: load_extend = word;
        endcase
    endfunction

endpackage

// File: rtl/l1c_set_state.sv
// Per-set valid bits and true-LRU bit; LRU exists only when WAYS = 2.
module l1c_set_state #(
    parameter int unsigned SETS  = 64,
    parameter int unsigned WAYS  = 2,
    parameter int unsigned IDX_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WAYS-1:0]  rd_valid,
    output logic             rd_lru,
    input  logic             fill_en,
    input  logic [IDX_W-1:0] fill_idx,
    input  logic             fill_way,
    input  logic             touch_en,
    input  logic [IDX_W-1:0] touch_idx,
    input  logic             touch_way
);

    logic [SETS-1:0][WAYS-1:0] valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx][fill_way] <= 1'b1;
        end
    end

    assign rd_valid = valid_q[rd_idx];

    // rd_lru names the least-recently-used way; touching a way points it at the other one.
    if (WAYS > 1) begin : g_lru
        logic [SETS-1:0] lru_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                lru_q <= '0;
            end else if (touch_en) begin
                lru_q[touch_idx] <= ~touch_way;
            end
        end

        assign rd_lru = lru_q[rd_idx];
    end else begin : g_no_lru
        assign rd_lru = 1'b0;
    end

endmodule

// File: rtl/l1c_data_assoc.sv
// Write-through, no-write-allocate L1 data cache, 1/2-way with true LRU.
// Optional hit/miss counters are enabled with L1C_PERF_CNT_EN.
module l1c_data_assoc
    import l1c_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SETS       = 64,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              core_req,
    input  logic              core_write,
    input  logic [DATA_W-1:0] core_in,
    input  logic [2:0]        core_type,
    output logic [DATA_W-1:0] core_out,
    output logic              core_wait,
    output logic              D_req,
    output logic [ADDR_W-1:0] D_addr,
    output logic              D_write,
    output logic [DATA_W-1:0] D_in,
    output logic [2:0]        D_type,
    input  logic [DATA_W-1:0] D_out,
    input  logic              D_wait
`ifdef L1C_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int unsigned OFF_W  = $clog2(LINE_WORDS) + 2;
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int unsigned WCNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    l1c_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] in_q;
    logic [2:0]        type_q;
    logic              victim_q;
    logic              store_hit_q;
    logic [WCNT_W-1:0] word_cnt_q;

    logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
    logic [DATA_W-1:0] data_q [SETS][WAYS][LINE_WORDS];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WCNT_W-1:0] req_word;
    logic [1:0]        off;
    logic [WAYS-1:0]   rd_valid;
    logic              rd_lru;
    logic [WAYS-1:0]   hit_vec;
    logic              hit;
    logic              hit_way;
    logic              victim;
    logic              load_hit;
    logic              fill_done;
    logic              wr_done;
    logic [DATA_W-1:0] fill_word;
    logic [3:0]        st_be;
    logic [DATA_W-1:0] st_data;

    assign idx      = addr_q[OFF_W +: IDX_W];
    assign tag      = addr_q[ADDR_W-1 -: TAG_W];
    assign off      = addr_q[1:0];
    assign req_word = WCNT_W'((addr_q >> 2) & ADDR_W'(LINE_WORDS - 1));
    assign st_be    = be_from_type(type_q, off);
    assign st_data  = store_align(in_q, type_q, off);

    l1c_set_state #(
        .SETS  (SETS),
        .WAYS  (WAYS),
        .IDX_W (IDX_W)
    ) u_set_state (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (idx),
        .rd_valid  (rd_valid),
        .rd_lru    (rd_lru),
        .fill_en   (fill_done),
        .fill_idx  (idx),
        .fill_way  (victim_q),
        .touch_en  (fill_done || (state_q == LOOKUP && hit)),
        .touch_idx (idx),
        .touch_way ((state_q == LOOKUP) ? hit_way : victim_q)
    );

    always_comb begin
        hit_vec = '0;
        hit_way = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            hit_vec[w] = rd_valid[w] && (tag_q[idx][w] == tag);
            if (hit_vec[w]) hit_way = 1'(w);
        end
        hit = |hit_vec;
        victim = rd_lru;
        if (!rd_valid[0]) victim = 1'b0;
        else if (WAYS > 1 && !rd_valid[WAYS-1]) victim = 1'b1;
    end

    assign load_hit  = (state_q == LOOKUP) && !write_q && hit;
    assign fill_done = (state_q == FILL) && !D_wait && (word_cnt_q == WCNT_W'(LINE_WORDS - 1));
    assign wr_done   = (state_q == WRBACK) && !D_wait;
    // The last word is still on D_out when the fill completes, so bypass it.
    assign fill_word = (req_word == WCNT_W'(LINE_WORDS - 1)) ? D_out : data_q[idx][victim_q][req_word];

    always_comb begin
        core_wait = 1'b1;
        core_out  = '0;
        case (state_q)
            IDLE:    core_wait = core_req;
            LOOKUP:  core_wait = !load_hit;
            FILL:    core_wait = !fill_done;
            WRBACK:  core_wait = D_wait;
            default: core_wait = 1'b1;
        endcase
        if (load_hit) core_out = load_extend(data_q[idx][hit_way][req_word], type_q, off);
        else if (fill_done) core_out = load_extend(fill_word, type_q, off);
    end

    assign D_req   = (state_q == FILL) || (state_q == WRBACK);
    assign D_write = (state_q == WRBACK);
    assign D_addr  = (state_q == FILL)   ? ({addr_q[ADDR_W-1:OFF_W], OFF_W'(0)} | (ADDR_W'(word_cnt_q) << 2)) :
                     (state_q == WRBACK) ? addr_q : '0;
    assign D_in    = (state_q == WRBACK) ? st_data : '0;
    assign D_type  = (state_q == FILL) ? CT_W : (state_q == WRBACK) ? type_q : 3'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            in_q        <= '0;
            type_q      <= '0;
            victim_q    <= 1'b0;
            store_hit_q <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (core_req) begin
                    addr_q  <= core_addr;
                    write_q <= core_write;
                    in_q    <= core_in;
                    type_q  <= core_type;
                    state_q <= LOOKUP;
                end
                LOOKUP: begin
                    if (write_q) begin
                        store_hit_q <= hit;
                        state_q     <= WRBACK;
                    end else if (hit) begin
                        state_q <= IDLE;
                    end else begin
                        victim_q   <= victim;
                        word_cnt_q <= '0;
                        state_q    <= FILL;
                    end
                end
                FILL: if (!D_wait) begin
                    word_cnt_q <= word_cnt_q + 1'b1;
                    if (fill_done) state_q <= IDLE;
                end
                WRBACK: if (!D_wait) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == FILL && !D_wait) begin
            data_q[idx][victim_q][word_cnt_q] <= D_out;
            if (fill_done) tag_q[idx][victim_q] <= tag;
        end
        if (state_q == LOOKUP && write_q && hit) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (st_be[b]) data_q[idx][hit_way][req_word][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

`ifdef L1C_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if ((load_hit || (wr_done && store_hit_q)) && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            if ((fill_done || (wr_done && !store_hit_q)) && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
        end
    end
`endif

endmodule
